// File: rtl/vend_pkg.sv
// vend_pkg: shared encodings for the vending controller.
// Modes, error codes, FSM states and a width helper.
package vend_pkg;

  localparam logic [1:0] MODE_BUY = 2'b00;
  localparam logic [1:0] MODE_WDR = 2'b01;
  localparam logic [1:0] MODE_SUP = 2'b10;
  localparam logic [1:0] MODE_PRC = 2'b11;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_ID    = 3'd1,
    ERR_STOCK = 3'd2,
    ERR_CASH  = 3'd3,
    ERR_MOVF  = 3'd4,
    ERR_SOVF  = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_FINISH
  } state_e;

  // product id width, never below one bit
  function automatic int pid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: request/response bundle of the vending controller.
// master drives requests, slave is the controller.
interface vend_if
  import vend_pkg::*;
#(
  parameter int N_PROD  = 8,
  parameter int MONEY_W = 8,
  parameter int QTY_W   = 4
);
  localparam int PID_W = pid_w(N_PROD);

  logic               start;
  logic [1:0]         mode;
  logic [PID_W-1:0]   product_id;
  logic [QTY_W-1:0]   quantity;
  logic [MONEY_W-1:0] money_in;
  logic               busy;
  logic               done;
  logic               red_light;
  logic [2:0]         err_code;
  logic               dispense;
  logic [MONEY_W-1:0] change_out;
  logic [MONEY_W-1:0] machine_money;

  modport master (
    output start,
    output mode,
    output product_id,
    output quantity,
    output money_in,
    input  busy,
    input  done,
    input  red_light,
    input  err_code,
    input  dispense,
    input  change_out,
    input  machine_money
  );

  modport slave (
    input  start,
    input  mode,
    input  product_id,
    input  quantity,
    input  money_in,
    output busy,
    output done,
    output red_light,
    output err_code,
    output dispense,
    output change_out,
    output machine_money
  );

endinterface

// File: rtl/vend_store.sv
// vend_store: per-slot stock and price arrays.
// One combinational read port, one write port.
module vend_store
  import vend_pkg::*;
#(
  parameter int N_PROD  = 8,
  parameter int MONEY_W = 8,
  parameter int QTY_W   = 4,
  parameter int PID_W   = pid_w(N_PROD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PID_W-1:0]   rd_id,
  output logic [QTY_W-1:0]   rd_stock,
  output logic [MONEY_W-1:0] rd_price,
  input  logic               we,
  input  logic               wr_sel,
  input  logic [PID_W-1:0]   wr_id,
  input  logic [QTY_W-1:0]   wr_stock,
  input  logic [MONEY_W-1:0] wr_price
);

  logic [QTY_W-1:0]   stock [N_PROD];
  logic [MONEY_W-1:0] price [N_PROD];
  logic               rd_ok;
  logic               wr_ok;

  assign rd_ok = int'(rd_id) < N_PROD;
  assign wr_ok = int'(wr_id) < N_PROD;

  assign rd_stock = rd_ok ? stock[rd_id] : '0;
  assign rd_price = rd_ok ? price[rd_id] : '0;

  // write port: wr_sel picks price (1) or stock (0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PROD; i++) begin
        stock[i] <= '0;
        price[i] <= '0;
      end
    end else if (we && wr_ok) begin
      if (wr_sel) price[wr_id] <= wr_price;
      else        stock[wr_id] <= wr_stock;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending controller top with start/done handshake.
// FSM IDLE -> CHECK -> (VEND) -> FINISH, results held after done.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int N_PROD  = 8,
  parameter int MONEY_W = 8,
  parameter int QTY_W   = 4
) (
  input logic clk,
  input logic rst_n,
  vend_if.slave bus
);

  localparam int PID_W = pid_w(N_PROD);
  localparam int CW    = MONEY_W + QTY_W;
  localparam logic [CW:0] MM_MAX = (CW+1)'((1 << MONEY_W) - 1);

  state_e state, state_n;

  logic [1:0]         mode_q;
  logic [PID_W-1:0]   id_q;
  logic [QTY_W-1:0]   qty_q;
  logic [QTY_W-1:0]   cnt_q;
  logic [MONEY_W-1:0] money_q;
  logic [MONEY_W-1:0] mm_q;
  logic [MONEY_W-1:0] chg_q;
  logic [MONEY_W-1:0] chg_out_q;
  err_e               err_q;
  err_e               err_out_q;
  logic               done_q;
  logic               red_q;

  logic [QTY_W-1:0]   rd_stock;
  logic [MONEY_W-1:0] rd_price;
  logic               we;
  logic               wr_sel;
  logic [QTY_W-1:0]   wr_stock;
  logic [MONEY_W-1:0] wr_price;

  logic [CW-1:0]      cost;
  logic [CW:0]        msum;
  logic [QTY_W:0]     ssum;
  logic               id_ok;
  logic               accept;
  logic               mm_we;
  logic [MONEY_W-1:0] mm_n;
  logic [MONEY_W-1:0] chk_chg;
  err_e               chk_err;

  assign accept = (state == S_IDLE) && bus.start;
  assign id_ok  = int'(id_q) < N_PROD;
  assign cost   = CW'(rd_price) * CW'(qty_q);
  assign msum   = (CW+1)'(mm_q) + (CW+1)'(cost);
  assign ssum   = {1'b0, rd_stock} + {1'b0, qty_q};

  vend_store #(
    .N_PROD  (N_PROD),
    .MONEY_W (MONEY_W),
    .QTY_W   (QTY_W),
    .PID_W   (PID_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_id    (id_q),
    .rd_stock (rd_stock),
    .rd_price (rd_price),
    .we       (we),
    .wr_sel   (wr_sel),
    .wr_id    (id_q),
    .wr_stock (wr_stock),
    .wr_price (wr_price)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next state plus the single-cycle CHECK decision
  always_comb begin
    state_n  = state;
    we       = 1'b0;
    wr_sel   = 1'b0;
    wr_stock = rd_stock;
    wr_price = money_q;
    mm_we    = 1'b0;
    mm_n     = mm_q;
    chk_err  = ERR_NONE;
    chk_chg  = '0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_n = S_CHECK;
      end
      S_CHECK: begin
        state_n = S_FINISH;
        if (!id_ok) begin
          chk_err = ERR_ID;
          if (mode_q == MODE_BUY) chk_chg = money_q;
        end else begin
          unique case (1'b1)
            (mode_q == MODE_BUY): begin
              chk_chg = money_q;
              if (qty_q == '0) begin
                chk_err = ERR_NONE;
              end else if (rd_stock < qty_q) begin
                chk_err = ERR_STOCK;
              end else if (cost > CW'(money_q)) begin
                chk_err = ERR_CASH;
              end else if (msum > MM_MAX) begin
                chk_err = ERR_MOVF;
              end else begin
                we       = 1'b1;
                wr_stock = rd_stock - qty_q;
                mm_we    = 1'b1;
                mm_n     = mm_q + cost[MONEY_W-1:0];
                chk_chg  = money_q - cost[MONEY_W-1:0];
                state_n  = S_VEND;
              end
            end
            (mode_q == MODE_WDR): begin
              chk_chg = mm_q;
              mm_we   = 1'b1;
              mm_n    = '0;
            end
            (mode_q == MODE_SUP): begin
              if (ssum[QTY_W]) begin
                chk_err = ERR_SOVF;
              end else begin
                we       = 1'b1;
                wr_stock = ssum[QTY_W-1:0];
              end
            end
            default: begin
              we     = 1'b1;
              wr_sel = 1'b1;
            end
          endcase
        end
      end
      S_VEND: begin
        if (cnt_q == QTY_W'(1)) state_n = S_FINISH;
      end
      S_FINISH: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // request latch, cash, vend counter and held results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      id_q      <= '0;
      qty_q     <= '0;
      money_q   <= '0;
      cnt_q     <= '0;
      mm_q      <= '0;
      chg_q     <= '0;
      err_q     <= ERR_NONE;
      chg_out_q <= '0;
      err_out_q <= ERR_NONE;
      done_q    <= 1'b0;
      red_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mode_q  <= bus.mode;
        id_q    <= bus.product_id;
        qty_q   <= bus.quantity;
        money_q <= bus.money_in;
        red_q   <= 1'b0;
      end
      if (state == S_CHECK) begin
        chg_q <= chk_chg;
        err_q <= chk_err;
        cnt_q <= qty_q;
      end
      if (state == S_VEND) cnt_q <= cnt_q - QTY_W'(1);
      if (mm_we) mm_q <= mm_n;
      if (state == S_FINISH) begin
        done_q    <= 1'b1;
        red_q     <= (err_q != ERR_NONE);
        chg_out_q <= chg_q;
        err_out_q <= err_q;
      end
    end
  end

  assign bus.busy          = (state != S_IDLE);
  assign bus.dispense      = (state == S_VEND);
  assign bus.done          = done_q;
  assign bus.red_light     = red_q;
  assign bus.err_code      = err_out_q;
  assign bus.change_out    = chg_out_q;
  assign bus.machine_money = mm_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed tests for vend_ctrl.
// N_PROD=6 so that ids 6 and 7 are out of range.
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam int NP = 6;
  localparam int MW = 8;
  localparam int QW = 4;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  vend_if #(.N_PROD(NP), .MONEY_W(MW), .QTY_W(QW)) vif ();

  vend_ctrl #(.N_PROD(NP), .MONEY_W(MW), .QTY_W(QW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  // issue one request, observe until done (bounded)
  task automatic do_op(input logic [1:0] m, input int id, input int q,
                       input int money, output int lat, output int pulses,
                       output int mm2);
    @(negedge clk);
    vif.start = 1'b1;
    vif.mode = m;
    vif.product_id = PW'(id);
    vif.quantity = QW'(q);
    vif.money_in = MW'(money);
    lat = -1;
    pulses = 0;
    mm2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      vif.start = 1'b0;
      if (vif.dispense) pulses++;
      if (k == 2) mm2 = int'(vif.machine_money);
      if (vif.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d want 0", vif.busy); end
    checks++; if (vif.done !== 1'b0) begin errors++; $display("FAIL rst_done got %0d want 0", vif.done); end
    checks++; if (vif.red_light !== 1'b0) begin errors++; $display("FAIL rst_red got %0d want 0", vif.red_light); end
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL rst_err got %0d want 0", vif.err_code); end
    checks++; if (vif.dispense !== 1'b0) begin errors++; $display("FAIL rst_disp got %0d want 0", vif.dispense); end
    checks++; if (vif.change_out !== 8'd0) begin errors++; $display("FAIL rst_chg got %0d want 0", vif.change_out); end
    checks++; if (vif.machine_money !== 8'd0) begin errors++; $display("FAIL rst_mm got %0d want 0", vif.machine_money); end
    rst_n = 1'b1;
  endtask

  task automatic test_buy;
    int lat, p, m2;
    do_op(MODE_PRC, 3, 0, 5, lat, p, m2);
    checks++; if (lat !== 3) begin errors++; $display("FAIL prc_lat got %0d want 3", lat); end
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL prc_err got %0d want 0", vif.err_code); end
    do_op(MODE_SUP, 3, 4, 0, lat, p, m2);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sup_lat got %0d want 3", lat); end
    do_op(MODE_BUY, 3, 2, 12, lat, p, m2);
    checks++; if (lat !== 5) begin errors++; $display("FAIL buy_lat got %0d want 5", lat); end
    checks++; if (p !== 2) begin errors++; $display("FAIL buy_pulses got %0d want 2", p); end
    checks++; if (vif.change_out !== 8'd2) begin errors++; $display("FAIL buy_chg got %0d want 2", vif.change_out); end
    checks++; if (vif.machine_money !== 8'd10) begin errors++; $display("FAIL buy_mm got %0d want 10", vif.machine_money); end
    checks++; if (m2 !== 10) begin errors++; $display("FAIL buy_mm_early got %0d want 10", m2); end
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL buy_err got %0d want 0", vif.err_code); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL buy_busy got %0d want 0", vif.busy); end
  endtask

  task automatic test_stock_err;
    int lat, p, m2;
    do_op(MODE_BUY, 3, 3, 12, lat, p, m2);
    checks++; if (lat !== 3) begin errors++; $display("FAIL stk_lat got %0d want 3", lat); end
    checks++; if (vif.err_code !== 3'd2) begin errors++; $display("FAIL stk_err got %0d want 2", vif.err_code); end
    checks++; if (vif.red_light !== 1'b1) begin errors++; $display("FAIL stk_red got %0d want 1", vif.red_light); end
    checks++; if (vif.change_out !== 8'd12) begin errors++; $display("FAIL stk_chg got %0d want 12", vif.change_out); end
    checks++; if (vif.machine_money !== 8'd10) begin errors++; $display("FAIL stk_mm got %0d want 10", vif.machine_money); end
    checks++; if (p !== 0) begin errors++; $display("FAIL stk_pulses got %0d want 0", p); end
  endtask

  task automatic test_cash_err;
    int lat, p, m2;
    do_op(MODE_SUP, 3, 2, 0, lat, p, m2);
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL sup2_err got %0d want 0", vif.err_code); end
    do_op(MODE_BUY, 3, 3, 14, lat, p, m2);
    checks++; if (vif.err_code !== 3'd3) begin errors++; $display("FAIL cash_err got %0d want 3", vif.err_code); end
    checks++; if (vif.change_out !== 8'd14) begin errors++; $display("FAIL cash_chg got %0d want 14", vif.change_out); end
    checks++; if (vif.red_light !== 1'b1) begin errors++; $display("FAIL cash_red got %0d want 1", vif.red_light); end
    checks++; if (p !== 0) begin errors++; $display("FAIL cash_pulses got %0d want 0", p); end
    do_op(MODE_BUY, 3, 1, 5, lat, p, m2);
    checks++; if (vif.red_light !== 1'b0) begin errors++; $display("FAIL clr_red got %0d want 0", vif.red_light); end
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL clr_err got %0d want 0", vif.err_code); end
    checks++; if (vif.change_out !== 8'd0) begin errors++; $display("FAIL clr_chg got %0d want 0", vif.change_out); end
    checks++; if (vif.machine_money !== 8'd15) begin errors++; $display("FAIL clr_mm got %0d want 15", vif.machine_money); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL clr_lat got %0d want 4", lat); end
  endtask

  task automatic test_money_ovf;
    int lat, p, m2;
    do_op(MODE_PRC, 1, 0, 235, lat, p, m2);
    do_op(MODE_SUP, 1, 1, 0, lat, p, m2);
    do_op(MODE_BUY, 1, 1, 235, lat, p, m2);
    checks++; if (vif.machine_money !== 8'd250) begin errors++; $display("FAIL fill_mm got %0d want 250", vif.machine_money); end
    do_op(MODE_BUY, 3, 2, 10, lat, p, m2);
    checks++; if (vif.err_code !== 3'd4) begin errors++; $display("FAIL movf_err got %0d want 4", vif.err_code); end
    checks++; if (vif.change_out !== 8'd10) begin errors++; $display("FAIL movf_chg got %0d want 10", vif.change_out); end
    checks++; if (vif.machine_money !== 8'd250) begin errors++; $display("FAIL movf_mm got %0d want 250", vif.machine_money); end
    do_op(MODE_WDR, 0, 0, 0, lat, p, m2);
    checks++; if (vif.change_out !== 8'd250) begin errors++; $display("FAIL wdr_chg got %0d want 250", vif.change_out); end
    checks++; if (vif.machine_money !== 8'd0) begin errors++; $display("FAIL wdr_mm got %0d want 0", vif.machine_money); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wdr_lat got %0d want 3", lat); end
  endtask

  task automatic test_supply_err;
    int lat, p, m2;
    do_op(MODE_SUP, 0, 1, 0, lat, p, m2);
    do_op(MODE_SUP, 0, 15, 0, lat, p, m2);
    checks++; if (vif.err_code !== 3'd5) begin errors++; $display("FAIL sovf_err got %0d want 5", vif.err_code); end
    checks++; if (vif.change_out !== 8'd0) begin errors++; $display("FAIL sovf_chg got %0d want 0", vif.change_out); end
    do_op(MODE_SUP, 0, 14, 0, lat, p, m2);
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL sfull_err got %0d want 0", vif.err_code); end
    do_op(MODE_SUP, 0, 1, 0, lat, p, m2);
    checks++; if (vif.err_code !== 3'd5) begin errors++; $display("FAIL sovf2_err got %0d want 5", vif.err_code); end
  endtask

  task automatic test_bad_id;
    int lat, p, m2;
    do_op(MODE_BUY, 6, 1, 9, lat, p, m2);
    checks++; if (vif.err_code !== 3'd1) begin errors++; $display("FAIL bid_err got %0d want 1", vif.err_code); end
    checks++; if (vif.change_out !== 8'd9) begin errors++; $display("FAIL bid_chg got %0d want 9", vif.change_out); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL bid_lat got %0d want 3", lat); end
    do_op(MODE_PRC, 7, 0, 4, lat, p, m2);
    checks++; if (vif.err_code !== 3'd1) begin errors++; $display("FAIL bid2_err got %0d want 1", vif.err_code); end
    checks++; if (vif.change_out !== 8'd0) begin errors++; $display("FAIL bid2_chg got %0d want 0", vif.change_out); end
  endtask

  task automatic test_busy_ignore;
    int lat, p;
    @(negedge clk);
    vif.start = 1'b1;
    vif.mode = MODE_BUY;
    vif.product_id = PW'(3);
    vif.quantity = QW'(2);
    vif.money_in = MW'(10);
    lat = -1;
    p = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      vif.start = (k == 2);
      if (k == 2) begin
        vif.mode = MODE_WDR;
        vif.money_in = MW'(0);
      end
      if (vif.dispense) p++;
      if (vif.done) begin
        lat = k;
        break;
      end
    end
    vif.start = 1'b0;
    checks++; if (lat !== 5) begin errors++; $display("FAIL ign_lat got %0d want 5", lat); end
    checks++; if (p !== 2) begin errors++; $display("FAIL ign_pulses got %0d want 2", p); end
    checks++; if (vif.change_out !== 8'd0) begin errors++; $display("FAIL ign_chg got %0d want 0", vif.change_out); end
    repeat (3) @(negedge clk);
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %0d want 0", vif.busy); end
    checks++; if (vif.machine_money !== 8'd10) begin errors++; $display("FAIL ign_mm got %0d want 10", vif.machine_money); end
  endtask

  task automatic test_reset_mid;
    int lat, p, m2;
    do_op(MODE_SUP, 3, 3, 0, lat, p, m2);
    do_op(MODE_BUY, 6, 1, 7, lat, p, m2);
    @(negedge clk);
    vif.start = 1'b1;
    vif.mode = MODE_BUY;
    vif.product_id = PW'(3);
    vif.quantity = QW'(3);
    vif.money_in = MW'(15);
    @(negedge clk);
    vif.start = 1'b0;
    @(negedge clk);
    checks++; if (vif.dispense !== 1'b1) begin errors++; $display("FAIL mid_v1 got %0d want 1", vif.dispense); end
    @(negedge clk);
    checks++; if (vif.dispense !== 1'b1) begin errors++; $display("FAIL mid_v2 got %0d want 1", vif.dispense); end
    rst_n = 1'b0;
    #1;
    checks++; if (vif.dispense !== 1'b0) begin errors++; $display("FAIL mid_disp got %0d want 0", vif.dispense); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0d want 0", vif.busy); end
    checks++; if (vif.machine_money !== 8'd0) begin errors++; $display("FAIL mid_mm got %0d want 0", vif.machine_money); end
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL mid_err got %0d want 0", vif.err_code); end
    checks++; if (vif.change_out !== 8'd0) begin errors++; $display("FAIL mid_chg got %0d want 0", vif.change_out); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(MODE_BUY, 3, 1, 0, lat, p, m2);
    checks++; if (vif.err_code !== 3'd2) begin errors++; $display("FAIL post_stock got %0d want 2", vif.err_code); end
    do_op(MODE_SUP, 3, 1, 0, lat, p, m2);
    do_op(MODE_BUY, 3, 1, 0, lat, p, m2);
    checks++; if (vif.err_code !== 3'd0) begin errors++; $display("FAIL post_price got %0d want 0", vif.err_code); end
    checks++; if (p !== 1) begin errors++; $display("FAIL post_pulses got %0d want 1", p); end
    checks++; if (vif.machine_money !== 8'd0) begin errors++; $display("FAIL post_mm got %0d want 0", vif.machine_money); end
  endtask

  initial begin
    vif.start = 1'b0;
    vif.mode = 2'b00;
    vif.product_id = '0;
    vif.quantity = '0;
    vif.money_in = '0;
    test_reset();
    test_buy();
    test_stock_err();
    test_cash_err();
    test_money_ovf();
    test_supply_err();
    test_bad_id();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised vending-machine controller: the next-generation top for the vending design. It replaces per-mode clock toggling with a single clock, async active-low reset and a start/done handshake. It holds per-product stock and price, and serves four modes: customer purchase, owner withdraw, owner supply and owner set-price. Purchases dispense one unit per cycle, and the block reports change and an error code.

## Interface
Parameters:
- N_PROD, 8, number of product slots (product id width PID_W = $clog2(N_PROD))
- MONEY_W, 8, width of money values
- QTY_W, 4, width of quantities and stock counters

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request strobe; accepted only when busy=0
- mode  in  2  00 purchase, 01 withdraw, 10 supply, 11 set price; sampled with start
- product_id  in  PID_W  target slot; sampled with start
- quantity  in  QTY_W  purchase qty or supply amount; sampled with start
- money_in  in  MONEY_W  customer money (purchase) or new price (set price); sampled with start
- busy  out  1  request in progress
- done  out  1  one-cycle pulse when a request completes, success or error
- red_light  out  1  set with error, held until the next accepted start
- err_code  out  3  0 none, 1 bad id, 2 out of stock, 3 insufficient money, 4 machine money overflow, 5 stock overflow
- dispense  out  1  one pulse per unit vended
- change_out  out  MONEY_W  valid with done
- machine_money  out  MONEY_W  accumulated cash

## Operation
- States: IDLE, CHECK, VEND, FINISH.
- IDLE: on start with busy=0, latch all inputs, then go to CHECK. busy=1 from the next cycle.
- CHECK runs for exactly one cycle, evaluating in the priority order below:
  - bad id: product_id ≥ N_PROD → error 1.
  - Purchase:
    - cost = price[id] × qty, computed at MONEY_W+QTY_W bits.
    - qty=0 → success with change = money_in, nothing vended.
    - stock < qty → error 2.
    - cost > money_in → error 3.
    - machine_money + cost > 2^MONEY_W−1 → error 4.
    - Otherwise: stock −= qty, machine_money += cost, change = money_in − cost, then go to VEND.
  - Withdraw: change_out = machine_money, machine_money = 0. Always succeeds.
  - Supply: stock + quantity > 2^QTY_W−1 → error 5 with stock unchanged; otherwise add.
  - Set price: price[id] = money_in[MONEY_W−1:0].
  - On error: no state is modified and change_out = money_in for purchase (full refund), 0 otherwise. Go to FINISH.
- VEND: dispense=1 for qty consecutive cycles, counted by a down-counter, then go to FINISH.
- FINISH: done=1, red_light and err_code updated, then return to IDLE.
- start while busy=1 is ignored, with no side effects.

## Timing
- Reset values: every output 0; all stock 0; all prices 0; FSM in IDLE.
- Latency from the start cycle to done:
  - Non-purchase or error: 3 cycles.
  - Purchase: 3+qty cycles.
- Cycle alignment:
  - Stock, price and machine_money updates are visible the cycle after CHECK.
  - change_out and err_code are stable from FINISH until the next accepted start.
- Back-to-back: start may be asserted in the cycle after done and is accepted.
- Reset mid-operation aborts immediately: no partial dispense continues, and state reverts to reset values including stock and price.

## Structure
- Package vend_pkg holds:
  - mode encodings MODE_BUY, MODE_WDR, MODE_SUP, MODE_PRC;
  - the err_code enum;
  - the FSM state typedef.
- Sub-module vend_store: N_PROD×QTY_W stock array and N_PROD×MONEY_W price array, with a single read port (id) and a single write port, async-reset. The controller FSM, money register and vend counter stay in vend_ctrl.

## Test plan
- Reset, then set price id3=5, supply id3 +4, then buy id3 qty2 with money 12 → 2 dispense pulses, change 2, machine_money 10, stock 2, done at cycle 5 after start.
- Buy id3 qty3 with stock 2 → err 2, red_light=1, change 12, machine_money unchanged, no dispense.
- Price 5, qty 3, money 14 → err 3, refund 14. Then a valid buy clears red_light.
- MONEY_W=8, machine_money 250, buy cost 10 → err 4. Then withdraw → change 250, machine_money 0.
- Supply id0 +15 on stock 1 (QTY_W=4) → err 5, stock stays 1. product_id ≥ N_PROD with N_PROD=6 → err 1.
- start pulsed during VEND is ignored. Asserting rst_n=0 in the second VEND cycle → dispense drops the same cycle, and all outputs, stock and prices return to 0.
